mem_arbiter: RTL
================

// Module: mem_arbiter
// PURPOSE
//  Shares the single memory port (addr/wdata/rdata/mode/wen/ready) between NUM_MASTERS requesters,
//  e.g. the multi-cycle core and a DMA/debug master. Sits between the masters and the memory/bus slave.
//  Serialises one transaction at a time: one grant per transaction, no pipelining, no abort.
// PARAMETERS
//  NUM_MASTERS  2   number of requesters (2..8); index 0 is highest fixed priority
//  XLEN         32  address/data width
// PORTS
//  clk       in   1                 clock, rising edge
//  rst       in   1                 reset, asynchronous, active-high
//  m_req     in   NUM_MASTERS       per-master request; held high with payload stable until m_ready
//  m_wen     in   NUM_MASTERS       per-master write enable
//  m_mode    in   NUM_MASTERS*3     per-master access mode (same encoding as core mem_mode)
//  m_addr    in   NUM_MASTERS*XLEN  per-master address
//  m_wdata   in   NUM_MASTERS*XLEN  per-master write data
//  m_rdata   out  XLEN              read data, valid only when some m_ready bit is high
//  m_ready   out  NUM_MASTERS       one-cycle completion pulse to granted master
//  m_gnt     out  NUM_MASTERS       one-hot grant, high from issue until completion pulse inclusive
//  s_req     out  1                 slave request
//  s_wen     out  1                 slave write enable (never high unless s_req high)
//  s_mode    out  3                 slave access mode
//  s_addr    out  XLEN              slave address
//  s_wdata   out  XLEN              slave write data
//  s_rdata   in   XLEN              slave read data, sampled with s_ready
//  s_ready   in   1                 slave completion, one-cycle pulse while s_req high
// BEHAVIOUR
//  Reset: state=IDLE; all outputs 0; priority pointer=0. Mid-transaction reset aborts silently; no m_ready.
//  FSM (all outputs registered):
//   IDLE: if |m_req: winner g chosen by arbitration; latch g, copy master g payload into s_*;
//         s_req<=1, s_wen<=m_wen[g], m_gnt<=1<<g -> BUSY. Else stay, outputs 0.
//   BUSY: s_* held constant. On s_ready: m_rdata<=s_rdata, m_ready[g]<=1, s_req<=0, s_wen<=0 -> DONE.
//   DONE: m_ready<=0, m_gnt<=0, m_rdata<=0 -> IDLE.
//  Latency: req sampled in IDLE at edge n -> s_req high cycle n+1; s_ready sampled at edge k -> m_ready
//   high exactly cycle k+1 (one cycle). Min. transaction = 3 cycles; one IDLE cycle between transactions.
//  Master contract: drop or update m_req at the edge that ends its m_ready cycle; m_req still high in the
//   following IDLE cycle is a new request.
//  m_req[g] dropped during BUSY: ignored, transaction completes, m_ready still pulsed.
//  Other masters' req during BUSY/DONE: waits, no effect on s_*.
//  s_ready in IDLE/DONE: ignored. No timeout; a slave that never responds hangs the arbiter.
//  m_mode/m_wen/m_addr/m_wdata of non-granted masters never reach s_*.
// CONFIGURATION
//  MEM_ARB_ROUND_ROBIN_EN defined: round-robin; search starts at pointer p, wraps NUM_MASTERS-1 -> 0;
//   on grant to g, p<=(g+1) mod NUM_MASTERS (updated in IDLE->BUSY).
//  Undefined: fixed priority, lowest index wins; pointer logic absent; starvation allowed.
// TESTING
//  1 single read: m_req=01, m_addr[0]=0x80000000, s_ready at 2nd BUSY cycle, s_rdata=0xDEADBEEF
//    -> s_req cycles 1-2, m_ready=01 cycle 3, m_rdata=0xDEADBEEF, s_wen=0 throughout.
//  2 simultaneous: m_req=11 held (fixed prio) -> grants 01,01,01...; RR build -> grants 01,10,01,10.
//  3 write: m_req=10, m_wen=10, m_mode[1]=3'b010, m_wdata[1]=0x12345678, m_addr[1]=0x100
//    -> s_wen=1, s_mode=010, s_wdata=0x12345678, s_addr=0x100; m_ready=10 one cycle.
//  4 req drop: m_req[0] 1 then 0 in first BUSY cycle -> transaction completes, m_ready=01 still pulsed.
//  5 reset mid-BUSY: rst high async -> all outputs 0 same cycle, no m_ready; after release m_req=01
//    -> fresh grant, s_req after 1 cycle.
//  6 back-to-back: master 0 keeps m_req high after m_ready -> one IDLE cycle, new s_req next cycle.

Source files
------------

// File: rtl/mem_arbiter.sv
// Serialises NUM_MASTERS requesters onto one memory/bus slave port, one transaction at a time.
// Define MEM_ARB_ROUND_ROBIN_EN for round-robin arbitration; default is fixed priority (index 0).
module mem_arbiter #(
  parameter int unsigned NUM_MASTERS = 2,
  parameter int unsigned XLEN        = 32
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic [NUM_MASTERS-1:0]      m_req_i,
  input  logic [NUM_MASTERS-1:0]      m_wen_i,
  input  logic [NUM_MASTERS*3-1:0]    m_mode_i,
  input  logic [NUM_MASTERS*XLEN-1:0] m_addr_i,
  input  logic [NUM_MASTERS*XLEN-1:0] m_wdata_i,
  output logic [XLEN-1:0]             m_rdata_o,
  output logic [NUM_MASTERS-1:0]      m_ready_o,
  output logic [NUM_MASTERS-1:0]      m_gnt_o,
  output logic                        s_req_o,
  output logic                        s_wen_o,
  output logic [2:0]                  s_mode_o,
  output logic [XLEN-1:0]             s_addr_o,
  output logic [XLEN-1:0]             s_wdata_o,
  input  logic [XLEN-1:0]             s_rdata_i,
  input  logic                        s_ready_i
);

  localparam int unsigned IdxW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  state_e                 state_q, state_d;
  logic [XLEN-1:0]        m_rdata_q, m_rdata_d;
  logic [NUM_MASTERS-1:0] m_ready_q, m_ready_d;
  logic [NUM_MASTERS-1:0] m_gnt_q, m_gnt_d;
  logic                   s_req_q, s_req_d;
  logic                   s_wen_q, s_wen_d;
  logic [2:0]             s_mode_q, s_mode_d;
  logic [XLEN-1:0]        s_addr_q, s_addr_d;
  logic [XLEN-1:0]        s_wdata_q, s_wdata_d;

  logic            win_valid;
  logic [IdxW-1:0] win_idx;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  logic [IdxW-1:0] ptr_q, ptr_d;
  int unsigned     cand;
  logic [IdxW-1:0] cand_idx;

  // Search starts at the pointer and wraps past the top index back to 0.
  always_comb begin
    win_valid = 1'b0;
    win_idx   = '0;
    cand      = 0;
    cand_idx  = '0;
    for (int unsigned k = 0; k < NUM_MASTERS; k++) begin
      cand     = (32'(ptr_q) + k) % NUM_MASTERS;
      cand_idx = cand[IdxW-1:0];
      if (!win_valid && m_req_i[cand_idx]) begin
        win_valid = 1'b1;
        win_idx   = cand_idx;
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (state_q == StIdle && win_valid) begin
      ptr_d = (win_idx == IdxW'(NUM_MASTERS - 1)) ? '0 : win_idx + 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end
`else
  logic [IdxW-1:0] k_idx;

  always_comb begin
    win_valid = 1'b0;
    win_idx   = '0;
    k_idx     = '0;
    for (int unsigned k = 0; k < NUM_MASTERS; k++) begin
      k_idx = k[IdxW-1:0];
      if (!win_valid && m_req_i[k_idx]) begin
        win_valid = 1'b1;
        win_idx   = k_idx;
      end
    end
  end
`endif

  always_comb begin
    state_d   = state_q;
    m_rdata_d = m_rdata_q;
    m_ready_d = m_ready_q;
    m_gnt_d   = m_gnt_q;
    s_req_d   = s_req_q;
    s_wen_d   = s_wen_q;
    s_mode_d  = s_mode_q;
    s_addr_d  = s_addr_q;
    s_wdata_d = s_wdata_q;
    unique case (state_q)
      StIdle: begin
        m_rdata_d = '0;
        m_ready_d = '0;
        m_gnt_d   = '0;
        s_req_d   = 1'b0;
        s_wen_d   = 1'b0;
        s_mode_d  = '0;
        s_addr_d  = '0;
        s_wdata_d = '0;
        if (win_valid) begin
          state_d          = StBusy;
          s_req_d          = 1'b1;
          s_wen_d          = m_wen_i[win_idx];
          s_mode_d         = m_mode_i[win_idx*3 +: 3];
          s_addr_d         = m_addr_i[win_idx*XLEN +: XLEN];
          s_wdata_d        = m_wdata_i[win_idx*XLEN +: XLEN];
          m_gnt_d[win_idx] = 1'b1;
        end
      end
      StBusy: begin
        if (s_ready_i) begin
          state_d   = StDone;
          m_rdata_d = s_rdata_i;
          m_ready_d = m_gnt_q;
          s_req_d   = 1'b0;
          s_wen_d   = 1'b0;
        end
      end
      StDone: begin
        state_d   = StIdle;
        m_rdata_d = '0;
        m_ready_d = '0;
        m_gnt_d   = '0;
        s_mode_d  = '0;
        s_addr_d  = '0;
        s_wdata_d = '0;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= StIdle;
      m_rdata_q <= '0;
      m_ready_q <= '0;
      m_gnt_q   <= '0;
      s_req_q   <= 1'b0;
      s_wen_q   <= 1'b0;
      s_mode_q  <= '0;
      s_addr_q  <= '0;
      s_wdata_q <= '0;
    end else begin
      state_q   <= state_d;
      m_rdata_q <= m_rdata_d;
      m_ready_q <= m_ready_d;
      m_gnt_q   <= m_gnt_d;
      s_req_q   <= s_req_d;
      s_wen_q   <= s_wen_d;
      s_mode_q  <= s_mode_d;
      s_addr_q  <= s_addr_d;
      s_wdata_q <= s_wdata_d;
    end
  end

  assign m_rdata_o = m_rdata_q;
  assign m_ready_o = m_ready_q;
  assign m_gnt_o   = m_gnt_q;
  assign s_req_o   = s_req_q;
  assign s_wen_o   = s_wen_q;
  assign s_mode_o  = s_mode_q;
  assign s_addr_o  = s_addr_q;
  assign s_wdata_o = s_wdata_q;

endmodule
